sd_cmd_engine: RTL and testbench
================================

# sd_cmd_engine

Hardware SD-card command-line engine that replaces software bit-banging of the SD CMD pin. The processor writes a command index and argument over an Avalon-MM slave port. The block serialises the 48-bit command frame with a computed CRC7, waits for and captures a 48-bit response, and reports the result. It drives the SD CMD tri-state pad (cmd_out/cmd_oe/cmd_in) and generates sd_clk, sitting between the Nios II data master and the CMD pin.

## Interface

- CLK_DIV, 64: sd_clk half-period in clk cycles (≥2).
- NCR_MAX, 64: response-start timeout in sd_clk periods.

- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- address  in  3  register select
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe
- writedata  in  32  write data
- readdata  out  32  registered read data
- irq  out  1  done & irq_en
- sd_clk  out  1  SD clock, free-running after reset
- cmd_out  out  1  CMD pad output value
- cmd_oe  out  1  CMD pad output enable
- cmd_in  in  1  CMD pad input, synchronised inside by two flops

## Operation

- Reg 0 ARG (RW): command argument[31:0].
- Reg 1 CMD (W):
  - [5:0] index; [6] resp_exp; [7] crc_chk_dis (for R3).
  - A write in IDLE starts a transaction. A write while busy is ignored.
- Reg 2 STATUS:
  - [0] busy (R); [1] done; [2] timeout; [3] crc_err; [8] irq_en (RW).
  - Writing 1 to bit 1 clears bits 1–3. A clear does not occur while busy.
- Reg 3 RESP_ARG (R): captured response bits [39:8].
- Reg 4 RESP_HDR (R): [5:0] response index, [6] response end bit.
- Unused addresses read 0.
- Tx frame, MSB first: 0, 1, index[5:0], arg[31:0], CRC7[6:0], 1.
  - CRC7 polynomial x^7+x^3+1, init 0, computed over the first 40 bits.
- FSM:
  - IDLE: cmd_oe=0.
  - TX: 48 bits, cmd_oe=1.
  - If !resp_exp → DONE.
  - WAIT: cmd_oe=0; count sd_clk rising edges.
    - Sampled cmd_in=0 → RX (start bit counted).
    - NCR_MAX edges without a start bit → DONE with timeout=1.
  - RX: capture the remaining 47 bits.
    - crc_err=1 if the CRC over the first 40 received bits ≠ received CRC, or the end bit = 0.
    - The CRC comparison is suppressed when crc_chk_dis=1.
    - → DONE.
  - DONE: set done for one clk → IDLE.
- A new command overwrites RESP regs only on RX completion. Error flags are sticky until cleared.

## Timing

- sd_clk toggles every CLK_DIV clk cycles; one period is 2·CLK_DIV clk cycles.
- cmd_out/cmd_oe change in the clk cycle where sd_clk falls.
- cmd_in is sampled on the synchronised value at sd_clk rise.
- busy reads 1 starting the clk after the accepted CMD write.
- The first start bit is driven at the next sd_clk falling edge.
- TX lasts exactly 48 sd_clk periods. cmd_oe drops at the falling edge after the end bit.
- readdata latency: one clk, registered. Reads have no side effects.
- Reset values:
  - readdata=0, sd_clk=0, cmd_out=1, cmd_oe=0, irq=0.
  - All registers 0; FSM=IDLE.
- Reset mid-transaction aborts immediately (asynchronous): pad released, no flags set.

## Test plan

- CMD0, arg 0, resp_exp=0 → pad frame 0x40_00000000_95, cmd_oe high for 48 periods, then done=1, busy=0, no errors.
- CMD55, arg 0, resp_exp=1; card model returns 0x37_00000120_83 after 2 periods of Ncr → Tx frame 0x77_00000000_65; RESP_ARG=0x00000120, RESP_HDR[5:0]=0x37, crc_err=0, irq=1 when irq_en=1.
- Same response with its last CRC bit flipped → crc_err=1, done=1. With crc_chk_dis=1 → crc_err=0.
- resp_exp=1, cmd_in held 1 → timeout=1 after 64 sd_clk rises in WAIT. Write STATUS=0x2 → bits 1–3 read 0.
- CMD write to index 17 during TX of CMD0 → transmitted frame is unchanged CMD0; no second transaction starts.
- reset_n low at bit 20 of TX → cmd_oe=0 and cmd_out=1 immediately, all registers 0. A subsequent CMD0 transmits correctly.

Source files
------------

// File: rtl/sd_cmd_engine_if.sv
// Avalon-MM slave bus between the Nios II data master and the SD CMD engine.
interface sd_cmd_engine_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;

    modport master (output address, chipselect, write_n, writedata, input readdata, irq);
    modport slave  (input address, chipselect, write_n, writedata, output readdata, irq);
endinterface

// File: rtl/sd_cmd_engine.sv
// SD CMD-line engine: serialises a 48-bit command with CRC7, waits for and
// captures a 48-bit response, and reports status over Avalon-MM.
module sd_cmd_engine #(
    parameter int CLK_DIV = 64,
    parameter int NCR_MAX = 64
) (
    input  logic           clk,
    input  logic           reset_n,
    sd_cmd_engine_if.slave bus,
    output logic           sd_clk_o,
    output logic           cmd_out_o,
    output logic           cmd_oe_o,
    input  logic           cmd_in_i
);
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int WW = $clog2(NCR_MAX + 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_TX, S_WAIT, S_RX, S_DONE} state_t;

    // Bit-serial CRC7, polynomial x^7+x^3+1, init 0, MSB first.
    function automatic logic [6:0] crc7(input logic [39:0] d);
        logic [6:0] c;
        logic       fb;
        c = '0;
        for (int i = 39; i >= 0; i--) begin
            fb = d[i] ^ c[6];
            c  = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
        end
        return c;
    endfunction

    state_t        state_q;
    logic [DW-1:0] div_q;
    logic          sd_clk_q;
    logic          sync1_q, sync2_q;
    logic [47:0]   tx_sh_q;
    logic [5:0]    bit_q;
    logic [WW-1:0] wcnt_q;
    logic [46:0]   rx_sh_q;
    logic          resp_exp_q, crc_dis_q;
    logic [31:0]   arg_q;
    logic [31:0]   resp_arg_q;
    logic [5:0]    resp_idx_q;
    logic          resp_end_q;
    logic          done_q, tout_q, crcerr_q, irqen_q;
    logic          cmd_out_q, cmd_oe_q;
    logic [31:0]   rdata_q;

    logic          tick, rise, fall, busy, wr_en, cmd_wr;
    logic [47:0]   frame_d;
    logic [47:0]   rx_word_d;
    logic          rx_bad_d;
    logic [31:0]   rdata_d;
    logic          unused_d;

    assign tick   = (div_q == DW'(CLK_DIV - 1));
    assign rise   = tick & ~sd_clk_q;
    assign fall   = tick & sd_clk_q;
    assign busy   = (state_q != S_IDLE);
    assign wr_en  = bus.chipselect & ~bus.write_n;
    assign cmd_wr = wr_en && (bus.address == 3'd1) && (state_q == S_IDLE);

    assign frame_d = {2'b01, bus.writedata[5:0], arg_q,
                      crc7({2'b01, bus.writedata[5:0], arg_q}), 1'b1};

    // Full response word as it stands once the current sample is shifted in.
    assign rx_word_d = {rx_sh_q, sync2_q};
    assign rx_bad_d  = ~rx_word_d[0] |
                       (~crc_dis_q & (crc7(rx_word_d[47:8]) != rx_word_d[7:1]));
    assign unused_d  = ^{bus.writedata[31:9], rx_word_d[47:46]};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_q    <= '0;
            sd_clk_q <= 1'b0;
        end else if (tick) begin
            div_q    <= '0;
            sd_clk_q <= ~sd_clk_q;
        end else begin
            div_q    <= div_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= cmd_in_i;
            sync2_q <= sync1_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            tx_sh_q    <= '0;
            bit_q      <= '0;
            wcnt_q     <= '0;
            rx_sh_q    <= '0;
            resp_exp_q <= 1'b0;
            crc_dis_q  <= 1'b0;
            arg_q      <= '0;
            resp_arg_q <= '0;
            resp_idx_q <= '0;
            resp_end_q <= 1'b0;
            done_q     <= 1'b0;
            tout_q     <= 1'b0;
            crcerr_q   <= 1'b0;
            irqen_q    <= 1'b0;
            cmd_out_q  <= 1'b1;
            cmd_oe_q   <= 1'b0;
        end else begin
            if (wr_en && bus.address == 3'd0) arg_q <= bus.writedata;
            if (wr_en && bus.address == 3'd2) begin
                irqen_q <= bus.writedata[8];
                if (bus.writedata[1] && state_q == S_IDLE) begin
                    done_q   <= 1'b0;
                    tout_q   <= 1'b0;
                    crcerr_q <= 1'b0;
                end
            end

            case (state_q)
                S_IDLE: begin
                    if (cmd_wr) begin
                        tx_sh_q    <= frame_d;
                        resp_exp_q <= bus.writedata[6];
                        crc_dis_q  <= bus.writedata[7];
                        state_q    <= S_START;
                    end
                end
                S_START: begin
                    if (fall) begin
                        cmd_oe_q  <= 1'b1;
                        cmd_out_q <= tx_sh_q[47];
                        tx_sh_q   <= {tx_sh_q[46:0], 1'b1};
                        bit_q     <= 6'd1;
                        state_q   <= S_TX;
                    end
                end
                S_TX: begin
                    if (fall) begin
                        if (bit_q == 6'd48) begin
                            cmd_oe_q  <= 1'b0;
                            cmd_out_q <= 1'b1;
                            wcnt_q    <= '0;
                            state_q   <= resp_exp_q ? S_WAIT : S_DONE;
                        end else begin
                            cmd_out_q <= tx_sh_q[47];
                            tx_sh_q   <= {tx_sh_q[46:0], 1'b1};
                            bit_q     <= bit_q + 1'b1;
                        end
                    end
                end
                S_WAIT: begin
                    // The start bit itself is the first of the 48 received bits.
                    if (rise) begin
                        if (!sync2_q) begin
                            rx_sh_q <= '0;
                            bit_q   <= 6'd1;
                            state_q <= S_RX;
                        end else if (wcnt_q == WW'(NCR_MAX - 1)) begin
                            tout_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            wcnt_q  <= wcnt_q + 1'b1;
                        end
                    end
                end
                S_RX: begin
                    if (rise) begin
                        rx_sh_q <= rx_word_d[46:0];
                        bit_q   <= bit_q + 1'b1;
                        if (bit_q == 6'd47) begin
                            resp_arg_q <= rx_word_d[39:8];
                            resp_idx_q <= rx_word_d[45:40];
                            resp_end_q <= rx_word_d[0];
                            if (rx_bad_d) crcerr_q <= 1'b1;
                            state_q    <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        rdata_d = '0;
        case (bus.address)
            3'd0:    rdata_d = arg_q;
            3'd2:    rdata_d = {23'b0, irqen_q, 4'b0, crcerr_q, tout_q, done_q, busy};
            3'd3:    rdata_d = resp_arg_q;
            3'd4:    rdata_d = {25'b0, resp_end_q, resp_idx_q};
            default: rdata_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) rdata_q <= '0;
        else          rdata_q <= rdata_d;
    end

    assign bus.readdata = rdata_q;
    assign bus.irq      = done_q & irqen_q;
    assign sd_clk_o     = sd_clk_q;
    assign cmd_out_o    = cmd_out_q;
    assign cmd_oe_o     = cmd_oe_q;
endmodule

// File: tb/tb_sd_cmd_engine.sv
// Bench for sd_cmd_engine: directed protocol cases plus randomized commands
// checked against a frame/CRC reference model and an SD card response model.
module tb_sd_cmd_engine;
    localparam int CLK_DIV = 8;
    localparam int NCR_MAX = 64;

    logic clk = 1'b0, reset_n = 1'b1, cmd_in = 1'b1;
    logic sd_clk, cmd_out, cmd_oe;

    sd_cmd_engine_if bus();

    sd_cmd_engine #(.CLK_DIV(CLK_DIV), .NCR_MAX(NCR_MAX)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus),
        .sd_clk_o(sd_clk), .cmd_out_o(cmd_out), .cmd_oe_o(cmd_oe), .cmd_in_i(cmd_in)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0;
    logic [47:0] tx_bits = '1;
    int tx_n = 0, oe_cyc = 0;

    // Pad monitor: the card samples CMD on sd_clk rise.
    always @(posedge sd_clk) if (cmd_oe) begin
        tx_bits <= {tx_bits[46:0], cmd_out};
        tx_n    <= tx_n + 1;
    end
    always @(posedge clk) if (cmd_oe) oe_cyc <= oe_cyc + 1;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Polynomial long division by 0x89 (x^7+x^3+1).
    function automatic logic [6:0] ref_crc(input logic [39:0] d);
        logic [46:0] m;
        m = {d, 7'b0};
        for (int b = 46; b >= 7; b--) if (m[b]) m = m ^ (47'h89 << (b - 7));
        return m[6:0];
    endfunction

    function automatic logic [47:0] cmd_frame(input logic [5:0] idx, input logic [31:0] arg);
        return {2'b01, idx, arg, ref_crc({2'b01, idx, arg}), 1'b1};
    endfunction

    function automatic logic [47:0] resp_frame(input logic [5:0] idx, input logic [31:0] arg);
        return {2'b00, idx, arg, ref_crc({2'b00, idx, arg}), 1'b1};
    endfunction

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.address = a; bus.writedata = d; bus.write_n = 1'b0; bus.chipselect = 1'b1;
        @(negedge clk);
        bus.chipselect = 1'b0; bus.write_n = 1'b1;
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] d);
        @(negedge clk);
        bus.address = a; bus.chipselect = 1'b1; bus.write_n = 1'b1;
        @(negedge clk);
        d = bus.readdata;
        bus.chipselect = 1'b0;
    endtask

    task automatic chk_reg(input string tag, input logic [2:0] a, input logic [31:0] exp);
        logic [31:0] d;
        rd(a, d);
        chk(tag, d, exp);
    endtask

    task automatic wait_oe(input logic v, input int budget);
        int k = 0;
        while (cmd_oe !== v && k < budget) begin @(negedge clk); k++; end
        chk("wait_oe", cmd_oe, v);
    endtask

    task automatic wait_idle();
        logic [31:0] s;
        int k = 0;
        rd(3'd2, s);
        while (s[0] && k < 3000) begin rd(3'd2, s); k++; end
        chk("idle", s[0], 1'b0);
    endtask

    // Card: start bit sampled at sd_clk rise ncr+1 after the host releases CMD.
    task automatic send_resp(input logic [47:0] r, input int ncr);
        repeat (ncr) @(posedge sd_clk);
        for (int i = 47; i >= 0; i--) begin @(negedge sd_clk); cmd_in = r[i]; end
        @(negedge sd_clk); cmd_in = 1'b1;
    endtask

    task automatic run(input logic [5:0] idx, input logic [31:0] arg, input logic rexp,
                       input logic dis, input logic card, input logic [47:0] r, input int ncr);
        int bn, bc;
        bn = tx_n; bc = oe_cyc;
        wr(3'd0, arg);
        wr(3'd1, {24'b0, dis, rexp, idx});
        wait_oe(1'b1, 4 * CLK_DIV);
        wait_oe(1'b0, 100 * CLK_DIV);
        if (card) send_resp(r, ncr);
        wait_idle();
        chk("tx_frame", tx_bits, cmd_frame(idx, arg));
        chk("tx_bits", tx_n - bn, 48);
        chk("oe_cycles", oe_cyc - bc, 96 * CLK_DIV);
    endtask

    initial begin
        logic [47:0] r55, rr;
        logic [5:0]  idx, ridx;
        logic [31:0] arg, rarg, exp_arg;
        logic [6:0]  exp_hdr;
        logic        dis, ien, tout, cerr;
        int          mode, ncr, bn, k;

        bus.address = '0; bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.writedata = '0;
        r55 = 48'h370000012083;

        #2 reset_n = 1'b0;
        #1;
        chk("rst_cmd_oe", cmd_oe, 1'b0);
        chk("rst_cmd_out", cmd_out, 1'b1);
        chk("rst_sd_clk", sd_clk, 1'b0);
        chk("rst_irq", bus.irq, 1'b0);
        chk("rst_readdata", bus.readdata, 32'h0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        for (int a = 0; a < 5; a++) chk_reg("rst_reg", 3'(a), 32'h0);

        wr(3'd0, 32'hDEADBEEF);
        chk_reg("arg_rw", 3'd0, 32'hDEADBEEF);
        chk_reg("unused5", 3'd5, 32'h0);
        chk_reg("unused7", 3'd7, 32'h0);

        // CMD0, no response.
        run(6'd0, 32'h0, 1'b0, 1'b0, 1'b0, '0, 0);
        chk("cmd0_frame", tx_bits, 48'h400000000095);
        chk_reg("cmd0_status", 3'd2, 32'h2);
        chk("cmd0_irq", bus.irq, 1'b0);

        // CMD55 with R1 response and irq enabled.
        wr(3'd2, 32'h102);
        chk_reg("clr_status", 3'd2, 32'h100);
        run(6'd55, 32'h0, 1'b1, 1'b0, 1'b1, r55, 2);
        chk("cmd55_frame", tx_bits, 48'h770000000065);
        chk_reg("cmd55_status", 3'd2, 32'h102);
        chk_reg("cmd55_resp_arg", 3'd3, 32'h120);
        chk_reg("cmd55_resp_hdr", 3'd4, 32'h77);
        chk("cmd55_irq", bus.irq, 1'b1);

        // Last CRC bit corrupted.
        wr(3'd2, 32'h102);
        run(6'd55, 32'h0, 1'b1, 1'b0, 1'b1, r55 ^ 48'h2, 2);
        chk_reg("badcrc_status", 3'd2, 32'h10A);
        chk_reg("badcrc_resp_arg", 3'd3, 32'h120);
        wr(3'd2, 32'h102);
        run(6'd55, 32'h0, 1'b1, 1'b1, 1'b1, r55 ^ 48'h2, 2);
        chk_reg("crcdis_status", 3'd2, 32'h102);

        // Timeout: no start bit within NCR_MAX rises.
        wr(3'd2, 32'h2);
        bn = tx_n;
        wr(3'd0, 32'h1AA);
        wr(3'd1, 32'h48);
        wait_oe(1'b1, 4 * CLK_DIV);
        wait_oe(1'b0, 100 * CLK_DIV);
        repeat (NCR_MAX - 1) @(posedge sd_clk);
        chk_reg("tout_busy_before", 3'd2, 32'h1);
        @(posedge sd_clk);
        repeat (3) @(negedge clk);
        chk_reg("tout_status", 3'd2, 32'h6);
        chk("tout_frame", tx_bits, cmd_frame(6'd8, 32'h1AA));
        chk("tout_bits", tx_n - bn, 48);
        chk_reg("tout_resp_kept", 3'd3, 32'h120);
        wr(3'd2, 32'h2);
        chk_reg("tout_clear", 3'd2, 32'h0);

        // CMD write during TX is ignored.
        bn = tx_n;
        wr(3'd0, 32'h0);
        wr(3'd1, 32'h0);
        k = 0;
        while (tx_n - bn < 10 && k < 40 * CLK_DIV) begin @(negedge clk); k++; end
        wr(3'd1, 32'h51);
        wait_oe(1'b0, 100 * CLK_DIV);
        wait_idle();
        repeat (20 * CLK_DIV) @(negedge clk);
        chk("busywr_frame", tx_bits, 48'h400000000095);
        chk("busywr_bits", tx_n - bn, 48);
        chk("busywr_oe", cmd_oe, 1'b0);
        chk_reg("busywr_status", 3'd2, 32'h2);

        // Randomized commands against the card/CRC model.
        exp_arg = 32'h120;
        exp_hdr = 7'h77;
        for (int it = 0; it < 10; it++) begin
            idx  = 6'($urandom);
            arg  = $urandom;
            ridx = 6'($urandom);
            rarg = $urandom;
            mode = int'($urandom_range(0, 4));
            dis  = 1'($urandom_range(0, 1));
            ien  = 1'($urandom_range(0, 1));
            ncr  = int'($urandom_range(1, 20));
            rr   = resp_frame(ridx, rarg);
            if (mode == 2) rr[1] = ~rr[1];
            if (mode == 3) rr[0] = 1'b0;
            tout = (mode == 4);
            cerr = (mode == 2 && !dis) || (mode == 3);
            wr(3'd2, {23'b0, ien, 8'h02});
            run(idx, arg, mode != 0, dis, mode >= 1 && mode <= 3, rr, ncr);
            if (mode >= 1 && mode <= 3) begin
                exp_arg = rarg;
                exp_hdr = {rr[0], ridx};
            end
            chk_reg("rnd_status", 3'd2, {23'b0, ien, 4'b0, cerr, tout, 1'b1, 1'b0});
            chk("rnd_irq", bus.irq, ien);
            chk_reg("rnd_resp_arg", 3'd3, exp_arg);
            chk_reg("rnd_resp_hdr", 3'd4, {25'b0, exp_hdr});
        end

        // Asynchronous reset at bit 20 of TX.
        wr(3'd2, 32'h100);
        bn = tx_n;
        wr(3'd0, 32'h0);
        wr(3'd1, 32'h0);
        k = 0;
        while (tx_n - bn < 20 && k < 40 * CLK_DIV) begin @(negedge clk); k++; end
        chk("abort_reached", tx_n - bn, 20);
        #1 reset_n = 1'b0;
        #1;
        chk("abort_cmd_oe", cmd_oe, 1'b0);
        chk("abort_cmd_out", cmd_out, 1'b1);
        chk("abort_irq", bus.irq, 1'b0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        for (int a = 0; a < 5; a++) chk_reg("abort_reg", 3'(a), 32'h0);

        run(6'd0, 32'h0, 1'b0, 1'b0, 1'b0, '0, 0);
        chk("post_abort_frame", tx_bits, 48'h400000000095);
        chk_reg("post_abort_status", 3'd2, 32'h2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
